// File: rtl/apb_arb_pkg.sv
// Shared definitions for the round-robin APB requester arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after the last grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last) + off) % NUM_REQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin APB master sharing one completer between NUM_REQ requesters.
// Optional ACCESS timeout abort enabled by defining APB_TIMEOUT_EN.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [DATA_W-1:0]         PRDATA,
  input  logic                      PREADY
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] sel_oh;
  logic               gnt_any;
  logic               take;
  logic               done;
  logic               abort;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req_valid),
    .last    (last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // last doubles as the index of the requester owning the current transfer
  assign sel_oh    = NUM_REQ'(1) << last;
  assign take      = (state == ST_IDLE) && gnt_any;
  assign done      = (state == ST_ACCESS) && PREADY;
  assign PSEL      = (state != ST_IDLE);
  assign PENABLE   = (state == ST_ACCESS);
  assign req_ready = (state == ST_SETUP) ? sel_oh : '0;

`ifdef APB_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt;

  // counts wait states; abort fires on the TIMEOUT_CYC-th low-PREADY cycle
  assign abort = (state == ST_ACCESS) && !PREADY && (to_cnt == TO_LAST);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                          to_cnt <= '0;
    else if (state == ST_SETUP)            to_cnt <= '0;
    else if (state == ST_ACCESS && !PREADY) to_cnt <= to_cnt + 1'b1;
  end
`else
  logic to_unused;
  assign to_unused = (TIMEOUT_CYC > 0);
  assign abort     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (gnt_any) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (done || abort) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      last      <= IDX_W'(NUM_REQ - 1);
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= '0;
      if (take) begin
        last   <= gnt_idx;
        PWRITE <= |(req_write & gnt);
        PADDR  <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        PWDATA <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
      end
      if (done) begin
        rsp_valid <= sel_oh;
        rsp_rdata <= PWRITE ? '0 : PRDATA;
        rsp_err   <= 1'b0;
      end else if (abort) begin
        rsp_valid <= sel_oh;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: stimulus queues expected grants and
// completions, a negedge monitor pops and compares them as the DUT presents them.
module tb_apb_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            PCLK = 1'b0;
  logic            PRESETn;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
  logic [AW-1:0]   PADDR;
  logic            rsp_err, PSEL, PENABLE, PWRITE, PREADY;

  apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct { int idx; logic [AW-1:0] addr; int cyc; } gnt_t;
  typedef struct { int idx; logic [DW-1:0] rdata; logic err; int cyc; } rsp_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  gnt_t       mg;
  rsp_t       mr;
  logic [N-1:0] moh;

  always @(negedge PCLK) begin
    if (PRESETn === 1'b1) begin
      if (|req_ready) begin
        if (exp_gnt.size() == 0) check("unexpected_grant", 64'(req_ready), 64'd0);
        else begin
          mg = exp_gnt.pop_front();
          moh = '0; moh[mg.idx] = 1'b1;
          check("grant_onehot", 64'(req_ready), 64'(moh));
          check("grant_cycle", 64'(cyc), 64'(mg.cyc));
          check("setup_bus", {30'd0, PSEL, PENABLE, PADDR}, {30'd0, 2'b10, mg.addr});
        end
      end
      if (|rsp_valid) begin
        if (exp_rsp.size() == 0) check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        else begin
          mr = exp_rsp.pop_front();
          moh = '0; moh[mr.idx] = 1'b1;
          check("rsp_onehot", 64'(rsp_valid), 64'(moh));
          check("rsp_cycle", 64'(cyc), 64'(mr.cyc));
          check("rsp_data", {31'd0, rsp_err, rsp_rdata}, {31'd0, mr.err, mr.rdata});
        end
      end
    end
  end

  task automatic set_req(input int i, input bit v, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    req_valid[i] = v;
    req_write[i] = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  // Single isolated transfer; entered and left 1 time unit after a posedge in IDLE.
  task automatic xfer(input int i, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int waits);
    int t0;
    t0 = cyc;
    set_req(i, 1'b1, wr, a, wd);
    PRDATA = rd;
    PREADY = 1'b0;
    exp_gnt.push_back('{i, a, t0 + 1});
    exp_rsp.push_back('{i, wr ? '0 : rd, 1'b0, t0 + 3 + waits});
    for (int k = 1; k <= 2 + waits; k++) begin
      tick();
      if (k == 2) set_req(i, 1'b0, ~wr, ~a, ~wd);
      PREADY = (k == 2 + waits);
      if (k >= 2) begin
        @(negedge PCLK);
        check("access_bus", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {2'b11, wr, a, wd});
      end
    end
    tick();
    PREADY = 1'b0;
  endtask

  int t1;

  initial begin
    PRESETn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0;
    repeat (2) tick();
    check("reset_apb", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 64'd0);
    check("reset_rsp", {N'(0), req_ready, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    PRESETn = 1'b1;
    tick();

    // zero-wait write from req0, then 3-wait read from req1
    xfer(0, 1'b1, 32'd2, 32'hFFFF_FFFF, 32'h0, 0);
    xfer(1, 1'b0, 32'd4, 32'h0, 32'hA5A5_0001, 3);

    // both requesters held: grants alternate 0,1,0,1
    t1 = cyc;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h14, 32'h0);
    PRDATA = 32'h0000_C0DE;
    PREADY = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_gnt.push_back('{j % 2, (j % 2) ? 32'h14 : 32'h10, t1 + 1 + 3*j});
      exp_rsp.push_back('{j % 2, 32'h0000_C0DE, 1'b0, t1 + 3 + 3*j});
    end
    repeat (11) tick();
    req_valid = '0;
    repeat (2) tick();

    // reset during ACCESS of a req0 write; then req0 must win over req1
    PREADY = 1'b0;
    set_req(0, 1'b1, 1'b1, 32'h30, 32'h1234);
    exp_gnt.push_back('{0, 32'h30, cyc + 1});
    tick();
    tick();
    set_req(0, 1'b0, 1'b1, 32'h30, 32'h1234);
    tick();
    set_req(0, 1'b1, 1'b1, 32'h40, 32'h55);
    set_req(1, 1'b1, 1'b1, 32'h44, 32'h66);
    PRESETn = 1'b0;
    #1;
    check("reset_mid_apb", {PSEL, PENABLE, PADDR, PWDATA}, 64'd0);
    check("reset_mid_hs", {req_ready, rsp_valid}, 64'd0);
    tick();
    PREADY = 1'b1;
    tick();
    PRESETn = 1'b1;
    t1 = cyc;
    exp_gnt.push_back('{0, 32'h40, t1 + 1});
    exp_rsp.push_back('{0, 32'h0, 1'b0, t1 + 3});
    exp_gnt.push_back('{1, 32'h44, t1 + 4});
    exp_rsp.push_back('{1, 32'h0, 1'b0, t1 + 6});
    repeat (2) tick();
    req_valid[0] = 1'b0;
    repeat (3) tick();
    req_valid[1] = 1'b0;
    repeat (2) tick();
    PREADY = 1'b0;

`ifdef APB_TIMEOUT_EN
    t1 = cyc;
    set_req(0, 1'b1, 1'b0, 32'h60, 32'h0);
    PRDATA = 32'hDEAD_DEAD;
    exp_gnt.push_back('{0, 32'h60, t1 + 1});
    exp_rsp.push_back('{0, 32'h0, 1'b1, t1 + 18});
    repeat (2) tick();
    req_valid[0] = 1'b0;
    repeat (16) tick();
    @(negedge PCLK);
    check("abort_idle", {PSEL, PENABLE}, 64'd0);
    tick();
    xfer(1, 1'b0, 32'h64, 32'h0, 32'h0000_BEEF, 2);
    repeat (3) tick();
    check("hold_rsp", {rsp_err, rsp_rdata}, {1'b0, 32'h0000_BEEF});
`else
    xfer(1, 1'b0, 32'h50, 32'h0, 32'h600D_F00D, 100);
    repeat (3) tick();
    check("hold_rsp", {rsp_err, rsp_rdata}, {1'b0, 32'h600D_F00D});
`endif

    check("pending_grants", 64'(exp_gnt.size()), 64'd0);
    check("pending_rsps", 64'(exp_rsp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Round-robin APB master that shares one APB completer (the UART/GPIO APB slave) between NUM_REQ local requesters, e.g. the UART RX command path and the GPIO controller.
- Accepts one latched request at a time, runs a standard two-phase APB transfer (SETUP, then ACCESS until PREADY), and returns the read data and completion to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYC, 16, ACCESS cycles with PREADY low before abort; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  APB clock; the only clock.
- PRESETn  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester request; held until req_ready.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_ready  out  NUM_REQ  one-cycle accept pulse (one-hot).
- rsp_valid  out  NUM_REQ  one-cycle completion pulse (one-hot).
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata and rsp_err all go to 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
  - A transfer cut off by reset is dropped; no rsp_valid is issued for it.
- IDLE:
  - PSEL = 0, PENABLE = 0.
  - If any req_valid is high, grant g = the first set index searching last+1, last+2, … (modulo NUM_REQ).
  - On that edge: latch req_write[g], addr[g] and wdata[g] into PWRITE/PADDR/PWDATA; set last = g; go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL = 1, PENABLE = 0, req_ready[g] = 1.
  - The requester may drop or change its inputs from the next cycle on.
  - Next state is ACCESS unconditionally.
- ACCESS:
  - PSEL = 1, PENABLE = 1. PADDR, PWDATA and PWRITE are stable for the whole transfer.
  - PREADY = 0: stay in ACCESS (wait state).
  - PREADY = 1 at an edge: go to IDLE.
    - Read: rsp_rdata <= PRDATA.
    - Write: rsp_rdata <= 0.
    - rsp_err <= 0.
    - rsp_valid[g] = 1 for the following cycle only.
- Latency, zero wait states: request seen in IDLE at cycle 0 → SETUP at cycle 1 → ACCESS at cycle 2 → rsp_valid at cycle 3.
  - Each wait state adds 1 cycle.
  - Minimum spacing between transfer starts is 3 cycles (IDLE is always visited).
- After a transfer:
  - PADDR, PWDATA and PWRITE hold their last values.
  - rsp_rdata and rsp_err hold until the next completion.
- Simultaneous requests: only one grant per IDLE visit. Losers stay pending and are served in rotation order, so there is no starvation.
  - With all requesters continuously valid, grants rotate 0, 1, …, NUM_REQ-1, 0, …
- A requester whose req_valid rises during its own rsp_valid cycle is arbitrated normally in that IDLE cycle.
- Requester inputs are ignored outside IDLE.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter of ACCESS cycles with PREADY = 0 resets on entry to ACCESS.
  - When the count reaches TIMEOUT_CYC, abort: go to IDLE, set PSEL = PENABLE = 0 that edge, rsp_rdata <= 0, rsp_err <= 1, and pulse rsp_valid[g].
  - If PREADY = 1 on the same edge the limit is reached, the transfer completes normally (rsp_err = 0).
- Not defined: no counter; the block waits indefinitely for PREADY; rsp_err is tied to 0.

Decomposition:
- Shared package apb_arb_pkg: state encoding constants (ST_IDLE = 2'd0, ST_SETUP = 2'd1, ST_ACCESS = 2'd2) and default width constants.
- One sub-module, rr_arbiter:
  - Combinational round-robin selection from req_valid and last.
  - Outputs a one-hot grant and its index.
  - The top level holds the pointer register, FSM and APB/response registers.

Test Plan:
- After reset: req_valid[0] = 1, write, addr 2, wdata 32'hFFFFFFFF, PREADY tied 1 → req_ready[0] and PSEL at cycle 1, PENABLE at cycle 2, PADDR = 2 and PWDATA = FFFFFFFF in both, rsp_valid[0] at cycle 3, rsp_err = 0.
- Read from req1, addr 4, PRDATA = 32'hA5A50001, PREADY low for 3 ACCESS cycles → PSEL/PENABLE held 4 ACCESS cycles, PADDR stable, rsp_valid[1] with rsp_rdata = A5A50001 at cycle 6.
- req0 and req1 both valid after reset, both held continuously → grants in order 0, 1, 0, 1; exactly one req_ready per transfer.
- Assert PRESETn = 0 mid-ACCESS → PSEL, PENABLE, req_ready and rsp_valid go to 0 immediately with no completion; after release, pending req1 and req0 together → req0 granted first.
- APB_TIMEOUT_EN, TIMEOUT_CYC = 16, PREADY held 0 → abort after 16 ACCESS cycles, rsp_err = 1, rsp_rdata = 0; the next request completes normally.
- Without APB_TIMEOUT_EN, PREADY low for 100 cycles then high → no abort; completion 1 cycle after PREADY with rsp_err = 0.
